// File: rtl/matriz_pkg.sv
// Shared constants, FSM state type and width helper for the matrix writeback block.
package matriz_pkg;
  localparam int ROWS_DEF   = 10;
  localparam int COLS_DEF   = 10;
  localparam int CELL_W_DEF = 4;
  localparam int MEM_WORDS  = 2048;
  localparam int ADDR_W     = 11;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/matriz_writer_if.sv
// Word-write memory bus: the writer drives address/data/strobe, memory answers with ready.
interface matriz_writer_if;
  import matriz_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ready;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_ready);
endinterface

// File: rtl/matriz_index_counter.sv
// Row-major row/col walker with a parallel incrementing word address (no multiplier).
module matriz_index_counter
  import matriz_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      adv,
  output logic [idx_w(ROWS)-1:0]    row,
  output logic [idx_w(COLS)-1:0]    col,
  output logic [ADDR_W-1:0]         addr,
  output logic                      last
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clr) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = ADDR_W'(BASE_ADDR);
    end else if (adv) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign addr = addr_q;
  assign last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
endmodule

// File: rtl/matriz_writer.sv
// Snapshots a ROWSxCOLS matrix on start and writes it row-major, one word per cell,
// into the 2048-word memory space starting at BASE_ADDR, honouring mem_ready backpressure.
module matriz_writer
  import matriz_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int CELL_W    = CELL_W_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CELL_W-1:0]  matriz [ROWS][COLS],
  matriz_writer_if.master    mem,
  output logic               busy,
  output logic               done
);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  if (BASE_ADDR + ROWS * COLS > MEM_WORDS) begin : g_addr_range
    $error("matriz_writer: BASE_ADDR + ROWS*COLS exceeds the memory space");
  end

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [CELL_W-1:0]   snap_q [ROWS][COLS];
  logic [CELL_W-1:0]   snap_d [ROWS][COLS];

  logic                clr, adv, last;
  logic [RW-1:0]       row, nrow;
  logic [CW-1:0]       col, ncol;
  logic [ADDR_W-1:0]   addr;

  matriz_index_counter #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .BASE_ADDR (BASE_ADDR)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .adv  (adv),
    .row  (row),
    .col  (col),
    .addr (addr),
    .last (last)
  );

  // Data is registered, so it is fetched for the cell the counter moves to next.
  always_comb begin
    if (col == CW'(COLS - 1)) begin
      nrow = row + RW'(1);
      ncol = '0;
    end else begin
      nrow = row;
      ncol = col + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wdata_d = wdata_q;
    snap_d  = snap_q;
    clr     = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = matriz;
          clr     = 1'b1;
          state_d = ST_WRITE;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          wdata_d = WORD_W'(matriz[0][0]);
        end
      end
      ST_WRITE: begin
        if (mem.mem_ready) begin
          if (last) begin
            state_d = ST_DONE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            adv     = 1'b1;
            wdata_d = WORD_W'(snap_q[nrow][ncol]);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wdata_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          snap_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wdata_q <= wdata_d;
      snap_q  <= snap_d;
    end
  end

  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule
